// File: rtl/pc_fetch_unit_pkg.sv
// Shared core definitions for the instruction fetch stage: next-PC select
// encodings, bubble instruction and fetch FSM state encoding.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    PC_SRC_SEQ   = 2'd0,
    PC_SRC_PCREL = 2'd1,
    PC_SRC_REG   = 2'd2,
    PC_SRC_RSVD  = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD    = 2'd0,
    IFID_BUBBLE  = 2'd1,
    IFID_CAPTURE = 2'd2
  } ifid_op_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_STEP       = 32'd4;

  function automatic logic isRedirect(input pc_src_e src);
    return (src == PC_SRC_PCREL) || (src == PC_SRC_REG);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection and redirect alignment check.
module pc_next_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_pc_src,
  input  logic [31:0] i_target_pcrel,
  input  logic [31:0] i_target_reg,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc,
  output logic        o_redirect,
  output logic        o_misalign
);

  logic [31:0] w_plus4;
  logic [31:0] w_target;
  pc_src_e     w_src;

  assign w_src   = pc_src_e'(i_pc_src);
  assign w_plus4 = i_pc + PC_STEP;

  // The reserved encoding falls through to sequential; JALR drops bit 0.
  always_comb begin
    w_target = w_plus4;
    case (w_src)
      PC_SRC_PCREL: w_target = i_target_pcrel;
      PC_SRC_REG:   w_target = {i_target_reg[31:1], 1'b0};
      default:      w_target = w_plus4;
    endcase
  end

  assign o_pc_plus4 = w_plus4;
  assign o_next_pc  = w_target;
  assign o_redirect = isRedirect(w_src);
  assign o_misalign = o_redirect && (w_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and the
// BOOT/RUN/FAULT control FSM.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  PC_SRC_i,
  input  logic [31:0] TARGET_PCREL_i,
  input  logic [31:0] TARGET_REG_i,
  input  logic        STALL_i,
  output logic [31:0] IMEM_ADDR_o,
  input  logic [31:0] IMEM_RDATA_i,
  output logic [31:0] PC_D_o,
  output logic [31:0] PC_PLUS4_D_o,
  output logic [31:0] INSTR_D_o,
  output logic        VALID_D_o,
  output logic        MISALIGN_o
);

  fetch_state_e r_state;
  fetch_state_e w_nextState;
  logic [31:0]  r_pc;
  logic [31:0]  r_pcD;
  logic [31:0]  r_pcPlus4D;
  logic [31:0]  r_instrD;
  logic         r_validD;
  logic         r_misalign;

  logic [31:0]  w_pcPlus4;
  logic [31:0]  w_nextPc;
  logic         w_redirect;
  logic         w_misalign;
  logic         w_pcLoad;
  logic         w_setMisalign;
  ifid_op_e     w_ifidOp;

  pc_next_sel u_next_sel (
    .i_pc           (r_pc),
    .i_pc_src       (PC_SRC_i),
    .i_target_pcrel (TARGET_PCREL_i),
    .i_target_reg   (TARGET_REG_i),
    .o_pc_plus4     (w_pcPlus4),
    .o_next_pc      (w_nextPc),
    .o_redirect     (w_redirect),
    .o_misalign     (w_misalign)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_BOOT;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_BOOT:  w_nextState = ST_RUN;
      ST_RUN:   w_nextState = (w_redirect && w_misalign) ? ST_FAULT : ST_RUN;
      ST_FAULT: w_nextState = ST_FAULT;
      default:  w_nextState = ST_BOOT;
    endcase
  end

  // Redirect beats stall; a misaligned redirect freezes the PC but still flushes.
  always_comb begin
    w_pcLoad      = 1'b0;
    w_setMisalign = 1'b0;
    w_ifidOp      = IFID_HOLD;
    case (r_state)
      ST_BOOT: w_ifidOp = IFID_BUBBLE;
      ST_RUN: begin
        if (w_redirect) begin
          w_ifidOp = IFID_BUBBLE;
          if (w_misalign) w_setMisalign = 1'b1;
          else            w_pcLoad      = 1'b1;
        end else if (!STALL_i) begin
          w_pcLoad = 1'b1;
          w_ifidOp = IFID_CAPTURE;
        end
      end
      default: w_ifidOp = IFID_HOLD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc       <= RESET_PC;
      r_pcD      <= RESET_PC;
      r_pcPlus4D <= RESET_PC + PC_STEP;
      r_instrD   <= NOP_INSTR;
      r_validD   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      if (w_pcLoad) r_pc <= w_nextPc;
      if (w_setMisalign) r_misalign <= 1'b1;
      case (w_ifidOp)
        IFID_BUBBLE: begin
          r_instrD <= NOP_INSTR;
          r_validD <= 1'b0;
        end
        IFID_CAPTURE: begin
          r_pcD      <= r_pc;
          r_pcPlus4D <= w_pcPlus4;
          r_instrD   <= IMEM_RDATA_i;
          r_validD   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign IMEM_ADDR_o  = r_pc;
  assign PC_D_o       = r_pcD;
  assign PC_PLUS4_D_o = r_pcPlus4D;
  assign INSTR_D_o    = r_instrD;
  assign VALID_D_o    = r_validD;
  assign MISALIGN_o   = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a reference model pushes expected
// IF outputs to a scoreboard queue, compared one cycle later against the DUT.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  pcSrc;
  logic [31:0] targetPcrel;
  logic [31:0] targetReg;
  logic        stall;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic [31:0] pcD;
  logic [31:0] pcPlus4D;
  logic [31:0] instrD;
  logic        validD;
  logic        misalign;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pcD;
    logic [31:0] plus4;
    logic [31:0] instr;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t expQ[$];

  int totalCount = 0;
  int badCount   = 0;

  logic [31:0] mPc, mPcD, mPlus4, mInstr;
  logic        mValid, mMis, mBoot, mFault;

  always #5 clock = ~clock;

  assign imemRdata = imemAddr + 32'h100;

  pc_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk_i          (clock),
    .rst_i          (reset),
    .PC_SRC_i       (pcSrc),
    .TARGET_PCREL_i (targetPcrel),
    .TARGET_REG_i   (targetReg),
    .STALL_i        (stall),
    .IMEM_ADDR_o    (imemAddr),
    .IMEM_RDATA_i   (imemRdata),
    .PC_D_o         (pcD),
    .PC_PLUS4_D_o   (pcPlus4D),
    .INSTR_D_o      (instrD),
    .VALID_D_o      (validD),
    .MISALIGN_o     (misalign)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of one rising edge, written from the block's rules.
  task automatic modelStep(input logic rst, input logic [1:0] src,
                           input logic [31:0] pcrel, input logic [31:0] tReg,
                           input logic stl);
    logic [31:0] tgt;
    if (rst) begin
      mPc = RST_PC; mPcD = RST_PC; mPlus4 = RST_PC + 32'd4;
      mInstr = NOP; mValid = 1'b0; mMis = 1'b0; mBoot = 1'b1; mFault = 1'b0;
    end else if (mBoot) begin
      mBoot = 1'b0; mInstr = NOP; mValid = 1'b0;
    end else if (!mFault) begin
      if (src == 2'd1 || src == 2'd2) begin
        tgt = (src == 2'd1) ? pcrel : (tReg & 32'hFFFF_FFFE);
        mInstr = NOP; mValid = 1'b0;
        if (tgt[1:0] != 2'b00) begin
          mMis = 1'b1; mFault = 1'b1;
        end else begin
          mPc = tgt;
        end
      end else if (!stl) begin
        mPcD = mPc; mPlus4 = mPc + 32'd4; mInstr = mPc + 32'h100; mValid = 1'b1;
        mPc = mPc + 32'd4;
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rst, input logic [1:0] src,
                               input logic [31:0] pcrel, input logic [31:0] tReg,
                               input logic stl);
    exp_t e;
    reset = rst; pcSrc = src; targetPcrel = pcrel; targetReg = tReg; stall = stl;
    modelStep(rst, src, pcrel, tReg, stl);
    e.addr = mPc; e.pcD = mPcD; e.plus4 = mPlus4; e.instr = mInstr;
    e.valid = mValid; e.mis = mMis;
    expQ.push_back(e);
    @(posedge clock);
    #1;
    e = expQ.pop_front();
    checkOutput({tag, "_addr"},  imemAddr, e.addr);
    checkOutput({tag, "_pcD"},   pcD, e.pcD);
    checkOutput({tag, "_plus4"}, pcPlus4D, e.plus4);
    checkOutput({tag, "_instr"}, instrD, e.instr);
    checkOutput({tag, "_valid"}, {31'd0, validD}, {31'd0, e.valid});
    checkOutput({tag, "_mis"},   {31'd0, misalign}, {31'd0, e.mis});
  endtask

  initial begin
    logic [31:0] frozenPc;
    reset = 1'b1; pcSrc = 2'd0; targetPcrel = '0; targetReg = '0; stall = 1'b0;
    mPc = '0; mPcD = '0; mPlus4 = '0; mInstr = '0;
    mValid = 1'b0; mMis = 1'b0; mBoot = 1'b1; mFault = 1'b0;

    #2;
    applyStimulus("rst0", 1'b1, 2'd0, '0, '0, 1'b0);
    applyStimulus("rst1", 1'b1, 2'd0, '0, '0, 1'b0);
    checkOutput("reset_plus4", pcPlus4D, 32'h4);
    checkOutput("reset_instr", instrD, NOP);

    // Boot then straight-line fetch
    applyStimulus("boot", 1'b0, 2'd0, '0, '0, 1'b0);
    checkOutput("boot_addr", imemAddr, 32'h0);
    checkOutput("boot_valid", {31'd0, validD}, 32'd0);
    applyStimulus("seq1", 1'b0, 2'd0, '0, '0, 1'b0);
    checkOutput("seq1_addr", imemAddr, 32'h4);
    checkOutput("seq1_instr", instrD, 32'h100);
    applyStimulus("seq2", 1'b0, 2'd0, '0, '0, 1'b0);
    checkOutput("seq2_addr", imemAddr, 32'h8);
    checkOutput("seq2_instr", instrD, 32'h104);
    checkOutput("seq2_valid", {31'd0, validD}, 32'd1);
    applyStimulus("seq3", 1'b0, 2'd0, '0, '0, 1'b0);
    applyStimulus("seq4", 1'b0, 2'd0, '0, '0, 1'b0);
    checkOutput("seq4_addr", imemAddr, 32'h10);

    // Redirect while stalled
    applyStimulus("pcrel", 1'b0, 2'd1, 32'h40, '0, 1'b1);
    checkOutput("pcrel_addr", imemAddr, 32'h40);
    checkOutput("pcrel_instr", instrD, NOP);
    checkOutput("pcrel_pcD", pcD, 32'hC);
    applyStimulus("afterrel", 1'b0, 2'd0, '0, '0, 1'b0);
    checkOutput("afterrel_instr", instrD, 32'h140);

    // JALR clears bit 0
    applyStimulus("jalr", 1'b0, 2'd2, '0, 32'h81, 1'b0);
    checkOutput("jalr_addr", imemAddr, 32'h80);
    checkOutput("jalr_mis", {31'd0, misalign}, 32'd0);

    // Three stall cycles at 0x20
    applyStimulus("to1c", 1'b0, 2'd1, 32'h1C, '0, 1'b0);
    applyStimulus("to20", 1'b0, 2'd0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall", 1'b0, 2'd0, '0, '0, 1'b1);
      checkOutput("stall_addr", imemAddr, 32'h20);
      checkOutput("stall_instr", instrD, 32'h11C);
    end
    applyStimulus("unstall", 1'b0, 2'd0, '0, '0, 1'b0);
    checkOutput("unstall_addr", imemAddr, 32'h24);
    checkOutput("unstall_pcD", pcD, 32'h20);

    // Reset overriding a stall, then reserved select behaves as sequential
    applyStimulus("rststall", 1'b1, 2'd1, 32'h400, '0, 1'b1);
    applyStimulus("boot2", 1'b0, 2'd0, '0, '0, 1'b0);
    applyStimulus("rsvd", 1'b0, 2'd3, 32'h200, 32'h300, 1'b0);
    checkOutput("rsvd_addr", imemAddr, 32'h4);

    // Wrap at top of address space
    applyStimulus("totop", 1'b0, 2'd1, 32'hFFFF_FFFC, '0, 1'b0);
    applyStimulus("wrap", 1'b0, 2'd0, '0, '0, 1'b0);
    checkOutput("wrap_addr", imemAddr, 32'h0);
    checkOutput("wrap_plus4", pcPlus4D, 32'h0);
    checkOutput("wrap_pcD", pcD, 32'hFFFF_FFFC);

    // Random aligned traffic
    for (int i = 0; i < 40; i++) begin
      applyStimulus("rand", 1'b0, 2'($urandom_range(0, 3)),
                    {$urandom(), 2'b00} >> 2 << 2,
                    {$urandom() >> 2, 1'b0, 1'($urandom_range(0, 1))},
                    1'($urandom_range(0, 1)));
    end

    // Misaligned redirect faults until reset
    frozenPc = mPc;
    applyStimulus("misal", 1'b0, 2'd1, 32'h42, '0, 1'b0);
    checkOutput("misal_flag", {31'd0, misalign}, 32'd1);
    checkOutput("misal_pc", imemAddr, frozenPc);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("fault", 1'b0, 2'($urandom_range(0, 3)), 32'h100, 32'h200,
                    1'($urandom_range(0, 1)));
      checkOutput("fault_pc", imemAddr, frozenPc);
      checkOutput("fault_valid", {31'd0, validD}, 32'd0);
    end
    applyStimulus("clrfault", 1'b1, 2'd1, 32'h42, '0, 1'b0);
    checkOutput("clr_addr", imemAddr, RST_PC);
    checkOutput("clr_mis", {31'd0, misalign}, 32'd0);
    applyStimulus("boot3", 1'b0, 2'd0, '0, '0, 1'b0);
    applyStimulus("seq5", 1'b0, 2'd0, '0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: PC_FETCH_UNIT

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, addi x0,x0,0 used as bubble.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 PC_SRC_i  input  2  next-PC select from branch/jump resolution: 0 = sequential, 1 = PC-relative target (branch/JAL), 2 = register target (JALR), 3 = reserved.
REQ-006 TARGET_PCREL_i  input  32  PC-relative target computed in EX.
REQ-007 TARGET_REG_i  input  32  JALR target computed by the ALU.
REQ-008 STALL_i  input  1  hazard-unit stall; holds PC and IF/ID.
REQ-009 IMEM_ADDR_o  output  32  instruction memory address (current PC).
REQ-010 IMEM_RDATA_i  input  32  instruction word, combinational read of IMEM_ADDR_o.
REQ-011 PC_D_o  output  32  IF/ID registered PC.
REQ-012 PC_PLUS4_D_o  output  32  IF/ID registered PC+4.
REQ-013 INSTR_D_o  output  32  IF/ID registered instruction.
REQ-014 VALID_D_o  output  1  IF/ID holds a real (non-bubble) instruction.
REQ-015 MISALIGN_o  output  1  sticky fault: redirect target not word-aligned.

Function
REQ-016 The block SHALL implement FSM states BOOT, RUN, FAULT.
REQ-017 BOOT SHALL last exactly one cycle after reset release, drive IMEM_ADDR_o = RESET_PC, load IF/ID with bubble, then go to RUN.
REQ-018 In RUN, next PC SHALL be: PC_SRC_i=1 -> TARGET_PCREL_i; PC_SRC_i=2 -> {TARGET_REG_i[31:1],1'b0}; PC_SRC_i=0 -> PC+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); PC_SRC_i=3 -> treated as 0.
REQ-019 Priority SHALL be rst_i > redirect (PC_SRC_i in {1,2}) > STALL_i > sequential advance.
REQ-020 On redirect, PC SHALL load the target and IF/ID SHALL load bubble (INSTR_D_o = NOP_INSTR, VALID_D_o = 0, PC_D_o/PC_PLUS4_D_o unchanged), regardless of STALL_i.
REQ-021 On STALL_i without redirect, PC and all IF/ID outputs SHALL hold their values.
REQ-022 On sequential advance, IF/ID SHALL capture PC, PC+4, IMEM_RDATA_i and VALID_D_o = 1 in the same edge PC increments; fetch-to-IF/ID latency is one cycle.
REQ-023 A redirect target with bits [1:0] != 0 (after JALR bit-0 clear) SHALL set MISALIGN_o, move to FAULT, leave PC unchanged, load bubble into IF/ID.
REQ-024 In FAULT, PC and IF/ID SHALL hold, VALID_D_o = 0, all inputs except rst_i ignored; exit only via reset.
REQ-025 IMEM_ADDR_o SHALL equal the PC register combinationally, no extra pipeline.

Reset
REQ-026 On rst_i high at a rising edge: PC = RESET_PC, state = BOOT, PC_D_o = RESET_PC, PC_PLUS4_D_o = RESET_PC+4, INSTR_D_o = NOP_INSTR, VALID_D_o = 0, MISALIGN_o = 0.
REQ-027 rst_i asserted mid-stall, mid-redirect or in FAULT SHALL override all other inputs that cycle.

Structure
REQ-028 PC_SRC encodings (SEQ=0, PCREL=1, REG=2), NOP_INSTR value and FSM state encoding SHALL live in the shared core package, also used by PC_SRC_CTRL's consumers.
REQ-029 Next-PC selection and alignment check SHALL be one combinational sub-module, PC_NEXT_SEL; PC register, IF/ID register and FSM stay in the top.

Verification
REQ-030 Reset release, PC_SRC_i=0, no stall, IMEM returns addr+32'h100 -> IMEM_ADDR_o 0,4,8; INSTR_D_o bubble, then 32'h100, 32'h104 with VALID_D_o 0,1,1.
REQ-031 At PC=32'h10, PC_SRC_i=1, TARGET_PCREL_i=32'h40 with STALL_i=1 -> next PC 32'h40, IF/ID bubble, VALID_D_o=0; next cycle fetches 32'h40.
REQ-032 PC_SRC_i=2, TARGET_REG_i=32'h81 -> next PC 32'h80, no fault.
REQ-033 STALL_i high 3 cycles at PC=32'h20 -> IMEM_ADDR_o and all IF/ID outputs constant 3 cycles, advance to 32'h24 after release.
REQ-034 PC_SRC_i=1, TARGET_PCREL_i=32'h42 -> MISALIGN_o=1, PC frozen, VALID_D_o=0 until rst_i; rst_i clears to RESET_PC.
REQ-035 PC forced to 32'hFFFF_FFFC sequential -> next IMEM_ADDR_o 32'h0, PC_PLUS4_D_o 32'h0.
